// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Distance (1..n) from the round-robin pointer to channel j, wrapping at n.
    function automatic int rr_dist(input int j, input int ptr, input int n);
        int v_d;
        v_d = j - ptr;
        if (v_d <= 0) v_d = v_d + n;
        return v_d;
    endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after i_PTR, wrapping.
// Zero latency; no state, so backpressure is handled entirely by the parent.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int p_CHANNELS = 4,
    parameter int p_SEL_W    = $clog2(p_CHANNELS)
) (
    input  logic [p_CHANNELS-1:0] i_REQ,
    input  logic [p_SEL_W-1:0]    i_PTR,
    output logic [p_SEL_W-1:0]    o_GNT,
    output logic                  o_GNT_VLD
);

    always_comb begin
        int w_best;
        int w_dist;
        o_GNT     = '0;
        o_GNT_VLD = 1'b0;
        w_best    = p_CHANNELS + 1;
        w_dist    = 0;
        for (int j = 0; j < p_CHANNELS; j++) begin
            w_dist = rr_dist(j, int'(i_PTR), p_CHANNELS);
            if (i_REQ[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_GNT     = p_SEL_W'(j);
                o_GNT_VLD = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream mux with packet locking, select-steered or round-robin.
// One-cycle registered output; o_READY drops combinationally when the full output is stalled.
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter int p_WIDTH    = 8,
    parameter int p_CHANNELS = 4,
    parameter int p_MODE     = MODE_SEL,
    parameter int p_SEL_W    = $clog2(p_CHANNELS)
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic [p_SEL_W-1:0]            i_SEL,
    input  logic [p_CHANNELS-1:0]         i_VALID,
    input  logic [p_CHANNELS*p_WIDTH-1:0] i_DATA,
    input  logic [p_CHANNELS-1:0]         i_LAST,
    output logic [p_CHANNELS-1:0]         o_READY,
    output logic                          o_VALID,
    output logic [p_WIDTH-1:0]            o_DATA,
    output logic                          o_LAST,
    output logic [p_SEL_W-1:0]            o_CH,
    input  logic                          i_READY,
    output logic                          o_BUSY
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [p_SEL_W-1:0] r_lock_ch;
    logic [p_SEL_W-1:0] w_lock_nxt;
    logic [p_SEL_W-1:0] w_cand;
    logic               w_cand_vld;
    logic [p_SEL_W-1:0] w_gnt_ch;
    logic               w_gnt_vld;
    logic               w_can_load;
    logic               w_rdy_any;
    logic               w_sel_valid;
    logic [p_WIDTH-1:0] w_sel_data;
    logic               w_sel_last;
    logic               w_in_xfer;

    generate
        if (p_MODE == MODE_RR) begin : g_rr
            logic [p_SEL_W-1:0] r_rr_ptr;
            logic [p_SEL_W-1:0] w_unused_sel;

            assign w_unused_sel = i_SEL;

            rr_arbiter #(
                .p_CHANNELS (p_CHANNELS),
                .p_SEL_W    (p_SEL_W)
            ) u_arb (
                .i_REQ     (i_VALID),
                .i_PTR     (r_rr_ptr),
                .o_GNT     (w_cand),
                .o_GNT_VLD (w_cand_vld)
            );

            // Pointer moves only on last beats so arbitration happens at packet boundaries.
            always_ff @(posedge i_CLK or posedge i_RST) begin
                if (i_RST) begin
                    r_rr_ptr <= p_SEL_W'(p_CHANNELS - 1);
                end else if (w_in_xfer && w_sel_last) begin
                    r_rr_ptr <= w_gnt_ch;
                end
            end
        end else begin : g_sel
            // Out-of-range selects match no channel and so never produce a candidate.
            always_comb begin
                w_cand     = i_SEL;
                w_cand_vld = 1'b0;
                for (int k = 0; k < p_CHANNELS; k++) begin
                    if (i_SEL == p_SEL_W'(k)) begin
                        w_cand_vld = i_VALID[k];
                    end
                end
            end
        end
    endgenerate

    assign w_gnt_ch   = (r_state == ST_LOCKED) ? r_lock_ch : w_cand;
    assign w_gnt_vld  = (r_state == ST_LOCKED) || w_cand_vld;
    assign w_can_load = !o_VALID || i_READY;
    assign w_rdy_any  = !i_RST && w_gnt_vld && w_can_load;
    assign w_in_xfer  = w_rdy_any && w_sel_valid;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int k = 0; k < p_CHANNELS; k++) begin
            if (w_gnt_ch == p_SEL_W'(k)) begin
                w_sel_valid = i_VALID[k];
                w_sel_data  = i_DATA[k*p_WIDTH +: p_WIDTH];
                w_sel_last  = i_LAST[k];
            end
        end
    end

    always_comb begin
        o_READY = '0;
        for (int k = 0; k < p_CHANNELS; k++) begin
            if (w_rdy_any && (w_gnt_ch == p_SEL_W'(k))) begin
                o_READY[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_in_xfer && !w_sel_last) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock_nxt  = w_cand;
                end
            end
            ST_LOCKED: begin
                if (w_in_xfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_nxt;
        end
    end

    // A load takes priority over a drain so a stalled-free pipeline moves one beat per cycle.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_VALID <= 1'b0;
            o_DATA  <= '0;
            o_LAST  <= 1'b0;
            o_CH    <= '0;
        end else if (w_in_xfer) begin
            o_VALID <= 1'b1;
            o_DATA  <= w_sel_data;
            o_LAST  <= w_sel_last;
            o_CH    <= w_gnt_ch;
        end else if (o_VALID && i_READY) begin
            o_VALID <= 1'b0;
        end
    end

    assign o_BUSY = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: directed scenarios plus randomized traffic against a packet-level model.
module tb_stream_mux_nx1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4-channel instances (A: select mode, B: round-robin)
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        dn_rdy;

    logic [3:0] a_rdy, b_rdy;
    logic       a_ov, b_ov, a_ol, b_ol, a_busy, b_busy;
    logic [7:0] a_od, b_od;
    logic [1:0] a_och, b_och;

    logic [2:0]  c_sel, c_och, d_sel, d_och;
    logic [5:0]  c_vld, c_lst, c_rdy;
    logic [47:0] c_dat;
    logic [4:0]  d_vld, d_lst, d_rdy;
    logic [39:0] d_dat;
    logic        c_ov, c_ol, c_busy, d_ov, d_ol, d_busy;
    logic [7:0]  c_od, d_od;

    stream_mux_nx1 #(.p_WIDTH(8), .p_CHANNELS(4), .p_MODE(0)) u_a (
        .i_CLK(clk), .i_RST(rst), .i_SEL(sel), .i_VALID(vld), .i_DATA(dat), .i_LAST(lst),
        .o_READY(a_rdy), .o_VALID(a_ov), .o_DATA(a_od), .o_LAST(a_ol), .o_CH(a_och),
        .i_READY(dn_rdy), .o_BUSY(a_busy));

    stream_mux_nx1 #(.p_WIDTH(8), .p_CHANNELS(4), .p_MODE(1)) u_b (
        .i_CLK(clk), .i_RST(rst), .i_SEL(sel), .i_VALID(vld), .i_DATA(dat), .i_LAST(lst),
        .o_READY(b_rdy), .o_VALID(b_ov), .o_DATA(b_od), .o_LAST(b_ol), .o_CH(b_och),
        .i_READY(dn_rdy), .o_BUSY(b_busy));

    stream_mux_nx1 #(.p_WIDTH(8), .p_CHANNELS(6), .p_MODE(0)) u_c (
        .i_CLK(clk), .i_RST(rst), .i_SEL(c_sel), .i_VALID(c_vld), .i_DATA(c_dat), .i_LAST(c_lst),
        .o_READY(c_rdy), .o_VALID(c_ov), .o_DATA(c_od), .o_LAST(c_ol), .o_CH(c_och),
        .i_READY(dn_rdy), .o_BUSY(c_busy));

    stream_mux_nx1 #(.p_WIDTH(8), .p_CHANNELS(5), .p_MODE(0)) u_d (
        .i_CLK(clk), .i_RST(rst), .i_SEL(d_sel), .i_VALID(d_vld), .i_DATA(d_dat), .i_LAST(d_lst),
        .o_READY(d_rdy), .o_VALID(d_ov), .o_DATA(d_od), .o_LAST(d_ol), .o_CH(d_och),
        .i_READY(dn_rdy), .o_BUSY(d_busy));

    int n_err = 0;
    int n_chk = 0;

    // Reference model: locked channel (-1 when between packets), rr pointer, output register image
    int         m_lock, m_ptr, m_och;
    bit         m_ov, m_ol;
    logic [7:0] m_od;

    // Traffic sources: beats remaining in the current packet and the beat being offered
    int         s_left[4];
    logic [7:0] s_dat[4];
    bit         s_auto, s_gappy;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_lock = -1; m_ptr = 3; m_ov = 0; m_ol = 0; m_od = 8'h00; m_och = 0;
    endtask

    task automatic drive_src();
        for (int k = 0; k < 4; k++) begin
            vld[k] = (s_left[k] > 0) && (!s_gappy || $urandom_range(0, 4) != 0);
            dat[k*8 +: 8] = s_dat[k];
            lst[k] = (s_left[k] == 1);
        end
    endtask

    task automatic advance(input int x);
        if (x >= 0) begin
            exp_q.push_back(s_dat[x]);
            s_left[x] = s_left[x] - 1;
            s_dat[x] = 8'($urandom);
        end
        if (s_auto) begin
            for (int k = 0; k < 4; k++) begin
                if (s_left[k] == 0 && $urandom_range(0, 1) == 1) s_left[k] = $urandom_range(1, 4);
            end
        end
        drive_src();
    endtask

    task automatic apply_reset();
        rst = 1'b1; sel = 0; vld = 0; lst = 0; dat = 0; dn_rdy = 1'b1;
        c_sel = 0; c_vld = 0; c_lst = 0; c_dat = 0;
        d_sel = 0; d_vld = 0; d_lst = 0; d_dat = 0;
        for (int k = 0; k < 4; k++) begin
            s_left[k] = 0;
            s_dat[k] = 8'($urandom);
        end
        s_auto = 0; s_gappy = 0;
        model_reset();
        got_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: compare every output of the selected 4-channel DUT with the model mid-cycle.
    task automatic step(input bit rr, output int xch);
        logic [3:0] ordy, er;
        logic       ov, ol, busy;
        logic [7:0] od;
        logic [1:0] och;
        int         cand;
        bit         can;
        @(negedge clk);
        ordy = rr ? b_rdy : a_rdy;
        ov   = rr ? b_ov : a_ov;
        ol   = rr ? b_ol : a_ol;
        od   = rr ? b_od : a_od;
        och  = rr ? b_och : a_och;
        busy = rr ? b_busy : a_busy;
        can  = !m_ov || dn_rdy;
        cand = -1;
        if (m_lock >= 0) cand = m_lock;
        else if (!rr) begin
            if (vld[sel]) cand = int'(sel);
        end else begin
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (cand < 0 && vld[c]) cand = c;
            end
        end
        er = 4'b0000;
        if (cand >= 0 && can) er[cand] = 1'b1;
        n_chk++; if (ordy !== er) begin n_err++; $display("FAIL step_ready mode%0d: got %b want %b", rr, ordy, er); end
        n_chk++; if (ov !== m_ov) begin n_err++; $display("FAIL step_valid mode%0d: got %b want %b", rr, ov, m_ov); end
        n_chk++; if (od !== m_od) begin n_err++; $display("FAIL step_data mode%0d: got %h want %h", rr, od, m_od); end
        n_chk++; if (ol !== m_ol) begin n_err++; $display("FAIL step_last mode%0d: got %b want %b", rr, ol, m_ol); end
        n_chk++; if (och !== 2'(m_och)) begin n_err++; $display("FAIL step_ch mode%0d: got %0d want %0d", rr, och, m_och); end
        n_chk++; if (busy !== (m_lock >= 0)) begin n_err++; $display("FAIL step_busy mode%0d: got %b want %b", rr, busy, m_lock >= 0); end
        if (ov === 1'b1 && dn_rdy) got_q.push_back(od);
        xch = -1;
        if (cand >= 0 && can && vld[cand]) begin
            xch = cand;
            m_ov = 1; m_od = dat[cand*8 +: 8]; m_ol = lst[cand]; m_och = cand;
            if (lst[cand]) begin m_lock = -1; m_ptr = cand; end
            else m_lock = cand;
        end else if (m_ov && dn_rdy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int x;
        rst = 1'b1; sel = 2; vld = 4'hF; lst = 4'hF; dat = 32'hDEADBEEF; dn_rdy = 1'b1;
        c_sel = 5; c_vld = 6'h3F; c_lst = 6'h3F; c_dat = 48'h123456789ABC;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (a_rdy !== 4'b0) begin n_err++; $display("FAIL reset_ready_a: got %b want 0000", a_rdy); end
        n_chk++; if (b_rdy !== 4'b0) begin n_err++; $display("FAIL reset_ready_b: got %b want 0000", b_rdy); end
        n_chk++; if (c_rdy !== 6'b0) begin n_err++; $display("FAIL reset_ready_c: got %b want 000000", c_rdy); end
        n_chk++; if ({a_ov, a_ol, a_busy, b_ov, c_ov} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {a_ov, a_ol, a_busy, b_ov, c_ov}); end
        n_chk++; if ({a_od, a_och} !== 10'b0) begin n_err++; $display("FAIL reset_data_ch: got %h/%0d want 0/0", a_od, a_och); end
        apply_reset();
        step(0, x);
    endtask

    task automatic test_single_beat();
        int x;
        apply_reset();
        sel = 2; vld = 4'b0100; lst = 4'b0100; dat = 32'h00A50000; dn_rdy = 1'b1;
        #1;
        n_chk++; if (a_rdy !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", a_rdy); end
        step(0, x);
        n_chk++; if ({a_ov, a_od, a_och, a_ol} !== {1'b1, 8'hA5, 2'd2, 1'b1}) begin
            n_err++; $display("FAIL single_out: got v=%b d=%h ch=%0d l=%b want v=1 d=a5 ch=2 l=1", a_ov, a_od, a_och, a_ol);
        end
        vld = 4'b0;
        step(0, x);
    endtask

    task automatic test_lock_sel();
        int x;
        apply_reset();
        sel = 1; vld = 4'b1010; lst = 4'b1000; dat = 32'h44001100; dn_rdy = 1'b1;
        step(0, x);
        n_chk++; if ({a_od, a_och, a_busy} !== {8'h11, 2'd1, 1'b1}) begin n_err++; $display("FAIL lock_beat1: got d=%h ch=%0d busy=%b want 11/1/1", a_od, a_och, a_busy); end
        sel = 3; dat[15:8] = 8'h22;
        step(0, x);
        n_chk++; if ({a_od, a_och, a_busy} !== {8'h22, 2'd1, 1'b1}) begin n_err++; $display("FAIL lock_beat2: got d=%h ch=%0d busy=%b want 22/1/1", a_od, a_och, a_busy); end
        dat[15:8] = 8'h33; lst = 4'b1010;
        step(0, x);
        n_chk++; if ({a_od, a_och, a_ol, a_busy} !== {8'h33, 2'd1, 1'b1, 1'b0}) begin n_err++; $display("FAIL lock_beat3: got d=%h ch=%0d l=%b busy=%b want 33/1/1/0", a_od, a_och, a_ol, a_busy); end
        vld = 4'b1000;
        step(0, x);
        n_chk++; if ({a_od, a_och} !== {8'h44, 2'd3}) begin n_err++; $display("FAIL lock_next_grant: got d=%h ch=%0d want 44/3", a_od, a_och); end
        vld = 4'b0;
        step(0, x);
    endtask

    task automatic test_rr_cycle();
        int x;
        logic [31:0] d;
        apply_reset();
        vld = 4'hF; lst = 4'hF; dn_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dat = $urandom;
            d = dat;
            step(1, x);
            n_chk++; if ({b_ov, b_och, b_od} !== {1'b1, 2'(i % 4), d[(i % 4)*8 +: 8]}) begin
                n_err++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, b_ov, b_och, b_od, i % 4, d[(i % 4)*8 +: 8]);
            end
        end
        vld = 4'b0;
        step(1, x);
    endtask

    task automatic test_backpressure();
        int x;
        logic [7:0] held;
        apply_reset();
        sel = 0; s_left[0] = 4; drive_src();
        for (int i = 0; i < 2; i++) begin step(0, x); advance(x); end
        dn_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            held = a_od;
            #1;
            n_chk++; if (a_rdy !== 4'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, a_rdy); end
            step(0, x); advance(x);
            n_chk++; if (a_od !== held) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, a_od, held); end
        end
        dn_rdy = 1'b1;
        for (int i = 0; i < 12 && got_q.size() < 4; i++) begin step(0, x); advance(x); end
        n_chk++; if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_err++; $display("FAIL bp_count: got %0d beats want 4 (sent %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_sel_range();
        logic [47:0] cd;
        apply_reset();
        c_sel = 5; c_vld = 6'h3F; c_lst = 6'h3F; c_dat = {16'($urandom), 32'($urandom)}; cd = c_dat;
        #1;
        n_chk++; if (c_rdy !== 6'b100000) begin n_err++; $display("FAIL sel5_ready: got %b want 100000", c_rdy); end
        @(posedge clk); #1;
        n_chk++; if ({c_ov, c_och, c_od} !== {1'b1, 3'd5, cd[47:40]}) begin n_err++; $display("FAIL sel5_out: got v=%b ch=%0d d=%h want 1/5/%h", c_ov, c_och, c_od, cd[47:40]); end
        c_vld = 0;
        d_vld = 5'h1F; d_lst = 5'h1F; d_dat = {8'($urandom), 32'($urandom)};
        for (int s = 5; s <= 7; s++) begin
            d_sel = 3'(s);
            #1;
            n_chk++; if (d_rdy !== 5'b0) begin n_err++; $display("FAIL oor_ready sel=%0d: got %b want 00000", s, d_rdy); end
            @(posedge clk); #1;
            n_chk++; if (d_ov !== 1'b0) begin n_err++; $display("FAIL oor_valid sel=%0d: got %b want 0", s, d_ov); end
        end
        d_sel = 4;
        #1;
        n_chk++; if (d_rdy !== 5'b10000) begin n_err++; $display("FAIL sel4_ready: got %b want 10000", d_rdy); end
        @(posedge clk); #1;
        d_vld = 0;
    endtask

    task automatic test_reset_mid();
        int x;
        apply_reset();
        s_left[2] = 4; drive_src();
        for (int i = 0; i < 2; i++) begin step(1, x); advance(x); end
        n_chk++; if (b_busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b want 1", b_busy); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({b_ov, b_busy, b_rdy} !== 6'b0) begin n_err++; $display("FAIL midrst_async: got v=%b busy=%b rdy=%b want 0/0/0000", b_ov, b_busy, b_rdy); end
        @(posedge clk); #1 rst = 1'b0;
        model_reset(); exp_q.delete(); got_q.delete();
        s_left[0] = 1; s_left[2] = 4; drive_src();
        step(1, x); advance(x);
        n_chk++; if ({b_ov, b_och} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL midrst_first_grant: got v=%b ch=%0d want 1/0", b_ov, b_och); end
        for (int i = 0; i < 8; i++) begin step(1, x); advance(x); end
    endtask

    task automatic test_random(input bit rr);
        int x;
        bit drained;
        apply_reset();
        s_auto = 1; s_gappy = 1;
        advance(-1);
        for (int i = 0; i < 300; i++) begin
            dn_rdy = ($urandom_range(0, 3) != 0);
            if (!rr) sel = 2'($urandom);
            step(rr, x); advance(x);
        end
        s_auto = 0; s_gappy = 0; dn_rdy = 1'b1; drive_src();
        drained = 0;
        for (int i = 0; i < 300 && !drained; i++) begin
            if (s_left[0] == 0 && s_left[1] == 0 && s_left[2] == 0 && s_left[3] == 0 && !m_ov) drained = 1;
            else begin
                if (!rr) sel = 2'($urandom);
                step(rr, x); advance(x);
            end
        end
        n_chk++; if (!drained || got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL random_drain mode%0d: got %0d beats want %0d (drained=%0d)", rr, got_q.size(), exp_q.size(), drained);
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_chk++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_order mode%0d[%0d]: got %h want %h", rr, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_beat();
        test_lock_sel();
        test_rr_cycle();
        test_backpressure();
        test_sel_range();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
